// File: rtl/ms_stopwatch.sv
// Millisecond stopwatch: synchronizes the divider output and counts ticks
// as BCD SS.mmm, with run/pause, clear and a lap-hold display.
module ms_stopwatch #(
  parameter int SYNC_STAGES = 2,
  parameter int WRAP_SEC    = 99
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ms_clk,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        lap,
  output logic [19:0] time_bcd,
  output logic        running,
  output logic        lap_active,
  output logic        overflow,
  output logic        tick
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  localparam logic [3:0] WRAP_T = 4'(WRAP_SEC / 10);
  localparam logic [3:0] WRAP_O = 4'(WRAP_SEC % 10);

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   primed_q;
  logic [19:0]            count_q;
  logic [19:0]            hold_q;
  logic                   lap_q;
  logic                   ovf_q;
  logic                   tick_q;
  logic                   running_q;

  logic        ms_tick;
  logic        cnt_en;
  logic [20:0] count_d;

  // Bit 20 flags a wrap from WRAP_SEC.999 back to 00.000.
  function automatic logic [20:0] bcd_inc(input logic [19:0] v);
    logic [19:0] n;
    logic        w;
    n = v;
    w = 1'b0;
    if (v[3:0] != 4'd9) begin
      n[3:0] = v[3:0] + 4'd1;
    end else begin
      n[3:0] = 4'd0;
      if (v[7:4] != 4'd9) begin
        n[7:4] = v[7:4] + 4'd1;
      end else begin
        n[7:4] = 4'd0;
        if (v[11:8] != 4'd9) begin
          n[11:8] = v[11:8] + 4'd1;
        end else begin
          n[11:8] = 4'd0;
          if (v[19:16] == WRAP_T && v[15:12] == WRAP_O) begin
            n[19:12] = 8'd0;
            w        = 1'b1;
          end else if (v[15:12] != 4'd9) begin
            n[15:12] = v[15:12] + 4'd1;
          end else begin
            n[15:12] = 4'd0;
            n[19:16] = v[19:16] + 4'd1;
          end
        end
      end
    end
    return {w, n};
  endfunction

  assign ms_tick = sync_q[SYNC_STAGES-1] & ~prev_q & primed_q;
  assign cnt_en  = ms_tick & (state_q == RUN) & ~clear;
  assign count_d = bcd_inc(count_q);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      sync_q    <= '0;
      prev_q    <= 1'b0;
      primed_q  <= 1'b0;
      count_q   <= '0;
      hold_q    <= '0;
      lap_q     <= 1'b0;
      ovf_q     <= 1'b0;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], ms_clk};
      prev_q   <= sync_q[SYNC_STAGES-1];
      primed_q <= 1'b1;
      tick_q   <= cnt_en;
      if (clear) begin
        state_q   <= IDLE;
        count_q   <= '0;
        lap_q     <= 1'b0;
        ovf_q     <= 1'b0;
        running_q <= 1'b0;
      end else begin
        if (cnt_en) begin
          count_q <= count_d[19:0];
          if (count_d[20]) ovf_q <= 1'b1;
        end
        // Lap sees the current state and the pre-increment count.
        if (lap) begin
          unique case (state_q)
            RUN: begin
              lap_q <= ~lap_q;
              if (!lap_q) hold_q <= count_q;
            end
            PAUSE:   lap_q <= 1'b0;
            default: ;
          endcase
        end
        if (start_stop) begin
          unique case (state_q)
            RUN: begin
              state_q   <= PAUSE;
              running_q <= 1'b0;
            end
            default: begin
              state_q   <= RUN;
              running_q <= 1'b1;
            end
          endcase
        end
      end
    end
  end

  assign time_bcd   = lap_q ? hold_q : count_q;
  assign running    = running_q;
  assign lap_active = lap_q;
  assign overflow   = ovf_q;
  assign tick       = tick_q;

endmodule
